ram2matrix_scan: RTL and testbench

//  Reader side of the frame-buffer RAM that the ROM-to-RAM loader fills.

---
 rtl/ram2matrix_scan_pkg.sv | 29 ++
 rtl/ram2matrix_scan_serializer.sv | 47 ++++
 rtl/ram2matrix_scan.sv | 138 +++++++++++++
 tb/tb_ram2matrix_scan.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ram2matrix_scan_pkg.sv
// rtl/ram2matrix_scan_pkg.sv - frame-buffer geometry constants and scan FSM states
package ram2matrix_scan_pkg;

  localparam int FB_ROWS          = 32;
  localparam int FB_BYTE_COLS     = 5;
  localparam int FB_ADDR_W        = 8;
  localparam int FB_ROW_W         = 5;
  localparam int FB_DWELL         = 256;
  localparam int FB_LAST_COL_BASE = (FB_BYTE_COLS - 1) * FB_ROWS;
  localparam int FB_MAX_ADDR      = FB_ROWS * FB_BYTE_COLS - 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_RCK_H,
    S_RCK_L,
    S_SH_L,
    S_SH_H,
    S_LAT_H,
    S_LAT_L,
    S_DWELL
  } scan_state_e;

  // Buffer is column-major: consecutive rows of one byte-column are adjacent.
  function automatic int fb_addr(input int col, input int row, input int rows);
    return col * rows + row;
  endfunction

endpackage

// File: rtl/ram2matrix_scan_serializer.sv
// rtl/ram2matrix_scan_serializer.sv - shifts one byte MSB-first as 8 sclk low/high pairs
module ram2matrix_scan_serializer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       sdata_o,
  output logic       sclk_o,
  output logic       done_o
);

  logic [7:0] shreg_q;
  logic [2:0] bit_q;
  logic       active_q;
  logic       sclk_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q  <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
    end else if (load_i) begin
      shreg_q  <= data_i;
      bit_q    <= '0;
      active_q <= 1'b1;
      sclk_q   <= 1'b0;
    end else if (active_q) begin
      if (!sclk_q) begin
        sclk_q <= 1'b1;
      end else begin
        // Shift only after the high phase so sdata spans both halves of the bit.
        sclk_q  <= 1'b0;
        shreg_q <= {shreg_q[6:0], 1'b0};
        bit_q   <= bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          active_q <= 1'b0;
        end
      end
    end
  end

  assign sdata_o = shreg_q[7];
  assign sclk_o  = sclk_q;
  assign done_o  = active_q & sclk_q & (bit_q == 3'd7);

endmodule

// File: rtl/ram2matrix_scan.sv
// rtl/ram2matrix_scan.sv - scans the column-major frame buffer row by row into 595 column drivers
module ram2matrix_scan
  import ram2matrix_scan_pkg::*;
#(
  parameter int ROWS      = FB_ROWS,
  parameter int BYTE_COLS = FB_BYTE_COLS,
  parameter int ADDR_W    = FB_ADDR_W,
  parameter int ROW_W     = FB_ROW_W,
  parameter int DWELL     = FB_DWELL
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  input  logic [7:0]        ram_dout_i,
  output logic              ram_clk_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              sdata_o,
  output logic              sclk_o,
  output logic              latch_o,
  output logic              oe_n_o,
  output logic [ROW_W-1:0]  row_sel_o,
  output logic              frame_tick_o,
  output logic              busy_o
);

  localparam int BC_W = (BYTE_COLS > 1) ? $clog2(BYTE_COLS) : 1;
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  scan_state_e       state_q;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [BC_W-1:0]   byte_q;
  logic [DW_W-1:0]   dwell_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [ROW_W-1:0]  row_sel_q;
  logic              ram_clk_q, latch_q, oe_n_q, frame_tick_q, busy_q;
  logic              last_row, last_byte, ser_done;

  assign last_row  = (row_q == ROW_W'(ROWS - 1));
  assign last_byte = (byte_q == BC_W'(BYTE_COLS - 1));
  assign row_d     = last_row ? '0 : row_q + ROW_W'(1);

  ram2matrix_scan_serializer u_ser (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (state_q == S_RCK_L),
    .data_i (ram_dout_i),
    .sdata_o(sdata_o),
    .sclk_o (sclk_o),
    .done_o (ser_done)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      byte_q       <= '0;
      dwell_q      <= '0;
      ram_addr_q   <= '0;
      row_sel_q    <= '0;
      ram_clk_q    <= 1'b0;
      latch_q      <= 1'b0;
      oe_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ram_clk_q    <= 1'b0;
      latch_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          oe_n_q <= 1'b1;
          busy_q <= 1'b0;
          if (run_i) begin
            state_q <= S_ADDR;
            busy_q  <= 1'b1;
          end
        end
        S_ADDR: begin
          ram_addr_q <= ADDR_W'(fb_addr(int'(byte_q), int'(row_q), ROWS));
          ram_clk_q  <= 1'b1;
          state_q    <= S_RCK_H;
        end
        S_RCK_H: state_q <= S_RCK_L;
        S_RCK_L: state_q <= S_SH_L;
        S_SH_L:  state_q <= S_SH_H;
        S_SH_H: begin
          if (!ser_done) begin
            state_q <= S_SH_L;
          end else if (last_byte) begin
            byte_q    <= '0;
            latch_q   <= 1'b1;
            oe_n_q    <= 1'b1;
            row_sel_q <= row_q;
            state_q   <= S_LAT_H;
          end else begin
            byte_q  <= byte_q + BC_W'(1);
            state_q <= S_ADDR;
          end
        end
        S_LAT_H: begin
          oe_n_q  <= 1'b0;
          state_q <= S_LAT_L;
        end
        S_LAT_L: begin
          dwell_q      <= DW_W'(DWELL - 1);
          frame_tick_q <= last_row && (DWELL == 1);
          state_q      <= S_DWELL;
        end
        S_DWELL: begin
          if (dwell_q != '0) begin
            dwell_q <= dwell_q - DW_W'(1);
            // Registered pulse: arm it one cycle ahead so it lands on the final dwell cycle.
            frame_tick_q <= last_row && (dwell_q == DW_W'(1));
          end else begin
            row_q <= row_d;
            if (run_i) begin
              state_q <= S_ADDR;
            end else begin
              oe_n_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_clk_o    = ram_clk_q;
  assign ram_addr_o   = ram_addr_q;
  assign latch_o      = latch_q;
  assign oe_n_o       = oe_n_q;
  assign row_sel_o    = row_sel_q;
  assign frame_tick_o = frame_tick_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_ram2matrix_scan.sv
// tb/tb_ram2matrix_scan.sv - randomized scoreboard bench for ram2matrix_scan
module tb_ram2matrix_scan;

  localparam int ROWS   = 32;
  localparam int BCOLS  = 5;
  localparam int DWELL  = 4;
  localparam int PERIOD = BCOLS * 19 + 2 + DWELL;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [7:0] ram_dout = 8'h00;
  logic       ram_clk, sdata, sclk, latch, oe_n, frame_tick, busy;
  logic [7:0] ram_addr;
  logic [4:0] row_sel;

  logic [7:0] mem [256];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  ram2matrix_scan #(.DWELL(DWELL)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .run_i       (run),
    .ram_dout_i  (ram_dout),
    .ram_clk_o   (ram_clk),
    .ram_addr_o  (ram_addr),
    .sdata_o     (sdata),
    .sclk_o      (sclk),
    .latch_o     (latch),
    .oe_n_o      (oe_n),
    .row_sel_o   (row_sel),
    .frame_tick_o(frame_tick),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_clk) ram_dout <= mem[ram_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Scoreboard: rebuild each row from the buffer contents and compare at its latch.
  int         exp_row = 0, latch_cnt = 0, last_latch = 0, exp_tick = -1;
  int         nbits = 0, naddr = 0;
  logic [39:0] got_bits = '0, got_addrs = '0, last_bits = '0, eb, ea;
  logic        sclk_prev = 1'b0;
  logic [4:0]  rs_prev = '0;
  bit          gap_ok = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_row = 0; nbits = 0; naddr = 0; got_bits = '0; got_addrs = '0;
      gap_ok = 0; exp_tick = -1; sclk_prev = 1'b0; rs_prev = row_sel;
    end else begin
      if (!busy) gap_ok = 0;
      if (ram_clk) begin
        got_addrs = {got_addrs[31:0], ram_addr};
        naddr++;
      end
      if (sclk && !sclk_prev) begin
        got_bits = {got_bits[38:0], sdata};
        nbits++;
      end
      if (row_sel !== rs_prev) chk("rowsel_only_on_latch", latch, 1'b1);
      if (latch) begin
        eb = '0; ea = '0;
        for (int b = 0; b < BCOLS; b++) begin
          eb = {eb[31:0], mem[b * ROWS + exp_row]};
          ea = {ea[31:0], 8'(b * ROWS + exp_row)};
        end
        chk("latch_blank", oe_n, 1'b1);
        chk("row_sel", row_sel, exp_row);
        chk("sclk_edges", nbits, 40);
        chk("ram_reads", naddr, 5);
        chk("row_addrs", got_addrs, ea);
        chk("row_bits", got_bits, eb);
        if (gap_ok) chk("latch_gap", cyc - last_latch, PERIOD);
        if (exp_row == ROWS - 1) exp_tick = cyc + 1 + DWELL;
        last_latch = cyc; gap_ok = 1; last_bits = got_bits;
        exp_row = (exp_row + 1) % ROWS;
        nbits = 0; naddr = 0; got_bits = '0; got_addrs = '0;
        latch_cnt++;
      end
      if (frame_tick || cyc == exp_tick) chk("frame_tick", frame_tick, cyc == exp_tick);
      sclk_prev = sclk;
      rs_prev   = row_sel;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_latch(input int target);
    int lim;
    lim = (target - latch_cnt) * PERIOD + 400;
    for (int i = 0; i < lim && latch_cnt < target; i++) step();
    chk("wait_latch", latch_cnt >= target, 1'b1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2 * PERIOD && busy; i++) step();
    chk("reach_idle", busy, 1'b0);
    chk("idle_blank", oe_n, 1'b1);
  endtask

  task automatic randomize_mem();
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
  endtask

  initial begin
    int n, reads;
    rst = 1'b1;
    run = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'(a);
    mem[0] = 8'hA5;
    for (int b = 1; b < BCOLS; b++) mem[b * ROWS] = 8'h00;
    repeat (3) step();
    chk("rst_oe_n", oe_n, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_outs", {ram_clk, sclk, latch, frame_tick, sdata}, 5'b0);
    chk("rst_addr", ram_addr, 8'd0);
    chk("rst_rowsel", row_sel, 5'd0);
    rst = 1'b0;
    repeat (4) step();
    chk("idle_no_run", busy, 1'b0);

    // Full frame plus wrap with mem[a]=a and an A5 pattern in row 0 byte 0.
    run = 1'b1;
    wait_latch(1);
    chk("first_byte", last_bits[39:32], 8'hA5);
    chk("first_rest", last_bits[31:0], 32'h0);
    wait_latch(ROWS + 1);

    // Drop run while row 5 is shifting; it must still complete, then resume at 6.
    wait_latch(latch_cnt + ((4 - exp_row + ROWS) % ROWS) + 1);
    n = 0;
    while (!ram_clk && n < PERIOD) begin step(); n++; end
    chk("row5_fetch", ram_clk, 1'b1);
    repeat (30) step();
    run = 1'b0;
    wait_latch(latch_cnt + 1);
    chk("stop_row", row_sel, 5'd5);
    wait_idle();
    reads = 0;
    for (int i = 0; i < 40; i++) begin step(); reads += int'(ram_clk); end
    chk("idle_no_reads", reads, 0);
    randomize_mem();
    run = 1'b1;
    wait_latch(latch_cnt + 1);
    chk("resume_row", row_sel, 5'd6);

    // run falls exactly on the last dwell cycle of row 31.
    wait_latch(latch_cnt + ((ROWS - 1 - exp_row + ROWS) % ROWS) + 1);
    repeat (1 + DWELL) step();
    run = 1'b0;
    step();
    chk("edge_stop_busy", busy, 1'b0);
    chk("edge_stop_oe_n", oe_n, 1'b1);
    randomize_mem();
    run = 1'b1;
    wait_latch(latch_cnt + 1);
    chk("edge_resume_row", row_sel, 5'd0);

    // Reset while shifting: immediate blank, then restart from address 0.
    n = 0;
    while (!sclk && n < PERIOD) begin step(); n++; end
    rst = 1'b1;
    step();
    chk("midrst_oe_n", oe_n, 1'b1);
    chk("midrst_outs", {sclk, latch, ram_clk, busy}, 4'b0);
    randomize_mem();
    rst = 1'b0;
    n = 0;
    while (!ram_clk && n < 20) begin step(); n++; end
    chk("midrst_ram_clk", ram_clk, 1'b1);
    chk("midrst_first_addr", ram_addr, 8'd0);

    // Random stop/start points against fresh random buffer contents.
    for (int it = 0; it < 6; it++) begin
      wait_latch(latch_cnt + int'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 120)) step();
      run = 1'b0;
      wait_idle();
      randomize_mem();
      repeat ($urandom_range(1, 20)) step();
      run = 1'b1;
    end
    wait_latch(latch_cnt + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
